// File: rtl/xor_serial_arbiter.sv
// xor_serial_arbiter: round-robin arbiter and bit-serial sequencer in front of a
// shared 1-bit mux-based XOR cell. Two requesters submit W-bit operand pairs;
// the winner's pair is pushed through the cell LSB first, one bit per clock,
// and the W-bit result is returned on a single response port tagged with the
// requester id.
`timescale 1ns/1ps

// Shared 1-bit XOR built from a 2:1 mux: a selects between b and ~b.
module xor_gate_using_mux (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ? ~b : b;
endmodule

module xor_serial_arbiter #(
  parameter int W       = 8,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y,
  input  logic         rsp_ready,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [W-1:0]  res_next;
  logic [CW-1:0] cnt;
  logic          prio;
  logic          job_id;
  logic          grant_id;
  logic          accept;
  logic          cell_y;
  logic          last_bit;

  // Pick the winner: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Readies are held low while reset is asserted so nothing looks accepted.
  assign req0_ready = rst_n && (state == S_IDLE) && req0_valid && !grant_id;
  assign req1_ready = rst_n && (state == S_IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  xor_gate_using_mux u_cell (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .y (cell_y)
  );

  // Each new bit enters at the MSB, so after W shifts bit k sits at position k.
  assign res_next = {cell_y, res_sh[W-1:1]};
  assign last_bit = (cnt == CW'(W - 1));

  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Sequencer: accept a job, stream it through the cell, hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      prio   <= RR_INIT;
      job_id <= 1'b0;
      rsp_id <= 1'b0;
      rsp_y  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sh   <= grant_id ? req1_a : req0_a;
            b_sh   <= grant_id ? req1_b : req0_b;
            res_sh <= '0;
            job_id <= grant_id;
            prio   <= ~grant_id;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            rsp_y  <= res_next;
            rsp_id <= job_id;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
